// File: rtl/rf_debug_port_arbiter_pkg.sv
// Shared constants and state encoding for the register-file debug port arbiter.
// Optional feature macro: RF_DBG_HOLD_EN (adds the HOLD state and i_DbgHold input).
package rf_debug_port_arbiter_pkg;

  localparam int BUS_MSB          = 31;
  localparam int DEF_DATA_W       = BUS_MSB + 1;
  localparam int DEF_ADDR_W       = 5;
  localparam int DEF_DRAIN_CYCLES = 3;
  // Drain counter width; DRAIN_CYCLES is limited to 1..15.
  localparam int CNT_W            = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ACK    = 3'd3,
    ST_HOLD   = 3'd4
  } rf_dbg_state_e;

  // Counter preload so that DRAIN lasts exactly 'cycles' clocks.
  function automatic logic [CNT_W-1:0] drain_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/rf_dbg_drain_timer.sv
// Loadable down-counter with a zero flag; times the pipeline drain before a debug access.
module rf_dbg_drain_timer
  import rf_debug_port_arbiter_pkg::*;
(
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Load,
  input  logic [CNT_W-1:0] i_LoadVal,
  input  logic             i_Dec,
  output logic             o_Zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_Load) begin
      cnt_d = i_LoadVal;
    end else if (i_Dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_Zero = (cnt_q == '0);

endmodule

// File: rtl/rf_debug_port_arbiter.sv
// Arbitrates the CPU register-file ports between the pipeline and a debug requester.
// A debug request stalls the front end, drains in-flight writebacks, performs one
// read or write over a four-phase req/ack handshake, then hands the ports back.
// Optional feature macro: RF_DBG_HOLD_EN keeps the pipeline stalled between
// transactions (HOLD state) so consecutive accesses skip the drain.
module rf_debug_port_arbiter
  import rf_debug_port_arbiter_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_PipeWe,
  input  logic [ADDR_W-1:0] i_PipeWrAddr,
  input  logic [DATA_W-1:0] i_PipeWrData,
  input  logic [ADDR_W-1:0] i_PipeRdAddrA,
  input  logic [ADDR_W-1:0] i_PipeRdAddrB,
  input  logic              i_DbgReq,
  input  logic              i_DbgWrite,
  input  logic [ADDR_W-1:0] i_DbgAddr,
  input  logic [DATA_W-1:0] i_DbgWrData,
`ifdef RF_DBG_HOLD_EN
  input  logic              i_DbgHold,
`endif
  input  logic [DATA_W-1:0] i_RfRdDataB,
  output logic              o_RfWe,
  output logic [ADDR_W-1:0] o_RfWrAddr,
  output logic [DATA_W-1:0] o_RfWrData,
  output logic [ADDR_W-1:0] o_RfRdAddrA,
  output logic [ADDR_W-1:0] o_RfRdAddrB,
  output logic              o_Stall,
  output logic              o_DbgAck,
  output logic [DATA_W-1:0] o_DbgRdData,
  output logic              o_Conflict
);

  rf_dbg_state_e     state_q, state_d;
  logic              req_wr_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_data_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              conflict_q;

  logic              capture;
  logic              timer_load;
  logic              timer_zero;
  logic              in_access;

  rf_dbg_drain_timer u_drain_timer (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Load    (timer_load),
    .i_LoadVal (drain_load(DRAIN_CYCLES)),
    .i_Dec     (state_q == ST_DRAIN),
    .o_Zero    (timer_zero)
  );

  // Next-state logic and RF port muxing; the pipeline owns the ports except in ACCESS.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    timer_load  = 1'b0;
    in_access   = 1'b0;
    o_Stall     = 1'b1;
    o_DbgAck    = 1'b0;
    o_RfWe      = i_PipeWe;
    o_RfWrAddr  = i_PipeWrAddr;
    o_RfWrData  = i_PipeWrData;
    o_RfRdAddrB = i_PipeRdAddrB;
    case (state_q)
      ST_IDLE: begin
        o_Stall = 1'b0;
        if (i_DbgReq) begin
          state_d    = ST_DRAIN;
          capture    = 1'b1;
          timer_load = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (timer_zero) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Pipeline write is dropped here; it is flagged as a conflict below.
        in_access  = 1'b1;
        o_RfWe     = req_wr_q;
        o_RfWrAddr = req_addr_q;
        o_RfWrData = req_data_q;
        if (!req_wr_q) begin
          o_RfRdAddrB = req_addr_q;
        end
        state_d = ST_ACK;
      end
      ST_ACK: begin
        o_DbgAck = 1'b1;
        if (!i_DbgReq) begin
`ifdef RF_DBG_HOLD_EN
          state_d = i_DbgHold ? ST_HOLD : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef RF_DBG_HOLD_EN
      ST_HOLD: begin
        // Pipeline is already drained and stalled, so go straight to ACCESS.
        if (i_DbgReq) begin
          state_d = ST_ACCESS;
          capture = 1'b1;
        end else if (!i_DbgHold) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch: the debug side may change its inputs once the request is taken.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      req_wr_q   <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
    end else if (capture) begin
      req_wr_q   <= i_DbgWrite;
      req_addr_q <= i_DbgAddr;
      req_data_q <= i_DbgWrData;
    end
  end

  // Read result register and sticky conflict flag, both updated only in ACCESS.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rd_data_q  <= '0;
      conflict_q <= 1'b0;
    end else if (in_access) begin
      if (!req_wr_q) begin
        rd_data_q <= i_RfRdDataB;
      end
      if (i_PipeWe) begin
        conflict_q <= 1'b1;
      end
    end
  end

  assign o_RfRdAddrA = i_PipeRdAddrA;
  assign o_DbgRdData = rd_data_q;
  assign o_Conflict  = conflict_q;

endmodule
